// File: rtl/tdm_channel_mux_if.sv
// Bundle of the serial-side and per-channel signals of the TDM channel mux.
// The slave modport is the mux itself; the master modport is whoever drives it.
interface tdm_channel_mux_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 12,
  parameter int CNT_WIDTH    = 16
);
  localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                               in_valid;
  logic                               in_sop;
  logic [DATA_WIDTH-1:0]              in_data;
  logic                               in_frame_sync;
  logic [NUM_CHANNELS-1:0]            ch_enable;
  logic [NUM_CHANNELS-1:0]            ch_valid;
  logic [NUM_CHANNELS-1:0]            ch_sop;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0]            ch_out_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_out_data;
  logic                               out_valid;
  logic [DATA_WIDTH-1:0]              out_data;
  logic [SLOT_W-1:0]                  slot_idx;
  logic                               frame_start;
  logic [CNT_WIDTH-1:0]               drop_count;

  modport slave (
    input  in_valid, in_sop, in_data, in_frame_sync, ch_enable, ch_out_valid, ch_out_data,
    output ch_valid, ch_sop, ch_data, out_valid, out_data, slot_idx, frame_start, drop_count
  );

  modport master (
    output in_valid, in_sop, in_data, in_frame_sync, ch_enable, ch_out_valid, ch_out_data,
    input  ch_valid, ch_sop, ch_data, out_valid, out_data, slot_idx, frame_start, drop_count
  );
endinterface

// File: rtl/tdm_channel_mux.sv
// TDM channel mux: splits a slotted serial byte stream onto per-channel lanes with
// per-channel packet tracking, and serialises per-channel return bytes back out.
module tdm_channel_mux #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 12,
  parameter int CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst,
  tdm_channel_mux_if.slave bus
);
  localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHANNELS - 1);

  typedef enum logic {CH_IDLE, CH_ACTIVE} ch_state_e;

  logic [SLOT_W-1:0]                  slot_q, slot_d, slot_s;
  ch_state_e [NUM_CHANNELS-1:0]       state_q, state_d;
  logic [NUM_CHANNELS-1:0]            ch_valid_q, ch_valid_d;
  logic [NUM_CHANNELS-1:0]            ch_sop_q, ch_sop_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data_q, ch_data_d;
  logic                               out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]              out_data_q, out_data_d;
  logic                               frame_start_q, frame_start_d;
  logic [CNT_WIDTH-1:0]               drop_q, drop_d;
  logic                               slot_en;
  logic                               accept;
  logic [DATA_WIDTH-1:0]              ret_data;

  always_comb begin
    // NOTE: every target of this block gets a default first, so no path can infer a latch.
    slot_s   = bus.in_frame_sync ? '0 : slot_q;
    slot_d   = (slot_s == LAST_SLOT) ? '0 : slot_s + 1'b1;
    slot_en  = bus.ch_enable[slot_s];
    accept   = bus.in_valid && slot_en && (bus.in_sop || state_q[slot_s] == CH_ACTIVE);
    ret_data = '0;
    state_d    = state_q;
    ch_valid_d = '0;
    ch_sop_d   = '0;
    ch_data_d  = ch_data_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (slot_s == SLOT_W'(i)) begin
        ret_data = bus.ch_out_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      // Disabling a channel aborts its packet regardless of which slot is current.
      if (!bus.ch_enable[i]) begin
        state_d[i] = CH_IDLE;
      end else if (slot_s == SLOT_W'(i) && bus.in_valid && bus.in_sop) begin
        state_d[i] = CH_ACTIVE;
      end
      if (accept && slot_s == SLOT_W'(i)) begin
        ch_valid_d[i] = 1'b1;
        ch_sop_d[i]   = bus.in_sop;
        ch_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end
    end
    drop_d = drop_q;
    if (bus.in_valid && !accept && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
    out_valid_d   = bus.ch_out_valid[slot_s] && slot_en;
    out_data_d    = out_valid_d ? ret_data : out_data_q;
    frame_start_d = (slot_s == '0);
  end

  // NOTE: ch_data is a register bank rather than a RAM, so it is cleared by reset like everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i]  <= CH_IDLE;
      end
      ch_valid_q    <= '0;
      ch_sop_q      <= '0;
      ch_data_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      frame_start_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample the pre-edge values.
      slot_q        <= slot_d;
      state_q       <= state_d;
      ch_valid_q    <= ch_valid_d;
      ch_sop_q      <= ch_sop_d;
      ch_data_q     <= ch_data_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      frame_start_q <= frame_start_d;
      drop_q        <= drop_d;
    end
  end

  assign bus.slot_idx    = slot_s;
  assign bus.ch_valid    = ch_valid_q;
  assign bus.ch_sop      = ch_sop_q;
  assign bus.ch_data     = ch_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: doc/tdm_channel_mux.md
TDM_CHANNEL_MUX -- requirements
Module: tdm_channel_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the byte lane width in bits.
REQ-002 Parameter NUM_CHANNELS, default 12, is the TDM slot/channel count; legal range 2..64.
REQ-003 Parameter CNT_WIDTH, default 16, is the drop counter width.
REQ-004 Localparam SLOT_W SHALL equal max(1, ceil(log2(NUM_CHANNELS))).
REQ-005 clk  in  1  sole clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  serial input byte valid for current slot.
REQ-008 in_sop  in  1  start-of-packet for current slot byte.
REQ-009 in_data  in  DATA_WIDTH  serial input byte.
REQ-010 in_frame_sync  in  1  forces current cycle to be slot 0.
REQ-011 ch_enable  in  NUM_CHANNELS  per-channel enable mask, bit i = channel i.
REQ-012 ch_valid  out  NUM_CHANNELS  registered per-channel byte strobe.
REQ-013 ch_sop  out  NUM_CHANNELS  registered per-channel start-of-packet.
REQ-014 ch_data  out  NUM_CHANNELS*DATA_WIDTH  per-channel byte, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 ch_out_valid  in  NUM_CHANNELS  per-channel return byte valid.
REQ-016 ch_out_data  in  NUM_CHANNELS*DATA_WIDTH  per-channel return byte, same packing.
REQ-017 out_valid  out  1  registered serial output valid.
REQ-018 out_data  out  DATA_WIDTH  registered serial output byte.
REQ-019 slot_idx  out  SLOT_W  effective slot of the current cycle.
REQ-020 frame_start  out  1  registered pulse, effective slot 0 seen previous cycle.
REQ-021 drop_count  out  CNT_WIDTH  saturating count of dropped input bytes.

Function
REQ-022 Slot counter: effective slot s = 0 when in_frame_sync=1, else counter value; counter next = (s == NUM_CHANNELS-1) ? 0 : s+1; never reaches NUM_CHANNELS.
REQ-023 slot_idx SHALL be combinational and equal s.
REQ-024 Per-channel state: IDLE, ACTIVE; reset to IDLE.
REQ-025 IDLE -> ACTIVE when s==i, ch_enable[i]=1, in_valid=1, in_sop=1.
REQ-026 ACTIVE -> IDLE whenever ch_enable[i]=0 (any slot); in_sop in ACTIVE restarts packet, stays ACTIVE.
REQ-027 Accept byte on slot i when in_valid=1, ch_enable[i]=1, and (in_sop=1 or state ACTIVE).
REQ-028 Accepted byte: next cycle ch_valid[i]=1, ch_sop[i]=in_sop, ch_data lane i=in_data; latency exactly 1 cycle.
REQ-029 ch_valid and ch_sop SHALL be single-cycle pulses; every lane not written holds its last ch_data.
REQ-030 Drop: in_valid=1 and not accepted (channel disabled or IDLE without in_sop) increments drop_count by 1, saturating at all-ones.
REQ-031 in_sop with in_valid=0 SHALL be ignored: no state change, no drop.
REQ-032 Return path: next out_valid = ch_out_valid[s] & ch_enable[s]; when that is 1 out_data <= ch_out_data lane s, else out_data holds.
REQ-033 Return-path latency exactly 1 cycle; at most one channel sampled per cycle; other channels' ch_out_valid ignored.
REQ-034 frame_start next = (s == 0).
REQ-035 in_frame_sync while counter already 0: no effect beyond normal slot 0.
REQ-036 Simultaneous in_frame_sync and in_valid: byte belongs to slot 0.

Reset
REQ-037 While rst=1: counter=0, all channel states IDLE, ch_valid=0, ch_sop=0, ch_data=0, out_valid=0, out_data=0, frame_start=0, drop_count=0.
REQ-038 Reset asserted mid-packet SHALL abort all packets; after release first cycle is slot 0, frame_start=1 on the following cycle.

Verification
REQ-039 N=12, all enabled, no sync, 24 cycles in_valid=1, in_sop=1, data=slot index -> ch_valid[i] pulses cycles i+1 and i+13, lane i=i, drop_count=0.
REQ-040 Counter at 7, in_frame_sync=1 with byte 0xA5 sop -> ch_valid[0]=1, lane 0=0xA5 next cycle, slot_idx sequence 0,1,2..., frame_start=1 next cycle.
REQ-041 ch_enable[3]=0, 5 valid bytes on slot 3 -> ch_valid[3] never asserts, drop_count=5; ch_enable[3]=0 mid-packet forces IDLE, next non-sop byte on slot 3 dropped.
REQ-042 Channel 5 IDLE, in_valid=1, in_sop=0 -> dropped, drop_count+1; CNT_WIDTH=4 with 20 drops -> drop_count=15.
REQ-043 ch_out_valid=all ones, lane i=0x10+i, all enabled -> out_data sequence 0x10..0x1B, out_valid=1, each one cycle after slot; ch_enable[2]=0 -> out_valid=0 and out_data held at 0x11 after slot 2.
REQ-044 rst asserted mid-packet for 1 cycle -> all outputs zero immediately, slot_idx=0 first cycle after release.
